// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch port, data port and memory macro bus of the unified memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: data-priority arbiter for a single-ported memory with fetch anti-starvation and response routing.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 2
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {NONE, RESP_IF, RESP_D} owner_t;
  owner_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic              if_gnt, d_gnt, if_resp, d_resp;
  logic [ADDR_W-1:0] addr_sel;
  always_comb begin
    if_gnt   = !rst && bus.if_req_i && (!bus.d_req_i || cnt == 3'(STARVE_LIMIT));
    d_gnt    = !rst && bus.d_req_i && !if_gnt;
    // only a contended cycle that fetch loses extends the streak
    cnt_n    = (bus.if_req_i && d_gnt) ? cnt + 3'd1 : 3'd0;
    state_n  = if_gnt ? RESP_IF : (d_gnt && !bus.d_we_i) ? RESP_D : NONE;
    addr_sel = d_gnt ? bus.d_addr_i : bus.if_addr_i;
    // a response still in flight when reset arrives is suppressed
    if_resp  = !rst && state == RESP_IF;
    d_resp   = !rst && state == RESP_D;
    bus.if_gnt_o    = if_gnt;
    bus.d_gnt_o     = d_gnt;
    bus.mem_en_o    = if_gnt || d_gnt;
    bus.mem_we_o    = d_gnt && bus.d_we_i;
    bus.mem_addr_o  = addr_sel;
    bus.mem_wdata_o = d_gnt ? bus.d_wdata_i : {DATA_W{1'b0}};
    bus.if_rvalid_o = if_resp;
    bus.if_rdata_o  = if_resp ? bus.mem_rdata_i : {DATA_W{1'b0}};
    bus.d_rvalid_o  = d_resp;
    bus.d_rdata_o   = d_resp ? bus.mem_rdata_i : {DATA_W{1'b0}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NONE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and random checks of the unified memory arbiter against a behavioural model.
module tb_unified_mem_arbiter;
  localparam int AW = 8, DW = 32, LIM = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0, n_bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // memory macro stand-in: read data appears the cycle after the enable
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {24'hC0FFEE, 8'(i)};
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en_o && bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      else if (bus.mem_en_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end
  end
  // reference model: streak of contended losses, pending read owner, architectural memory
  logic [DW-1:0] ref_mem [256];
  int streak, pend;
  logic [AW-1:0] pend_addr;
  initial begin
    logic eif, ed;
    for (int i = 0; i < 256; i++) ref_mem[i] = {24'hC0FFEE, 8'(i)};
    streak = 0;
    pend = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_if_gnt", bus.if_gnt_o, 0);
        check("rst_d_gnt", bus.d_gnt_o, 0);
        check("rst_mem_en", bus.mem_en_o, 0);
        check("rst_mem_we", bus.mem_we_o, 0);
        check("rst_if_rvalid", bus.if_rvalid_o, 0);
        check("rst_d_rvalid", bus.d_rvalid_o, 0);
        check("rst_if_rdata", bus.if_rdata_o, 0);
        check("rst_d_rdata", bus.d_rdata_o, 0);
        streak = 0;
        pend = 0;
      end else begin
        eif = bus.if_req_i && (!bus.d_req_i || streak >= LIM);
        ed  = bus.d_req_i && !eif;
        check("if_gnt", bus.if_gnt_o, eif);
        check("d_gnt", bus.d_gnt_o, ed);
        check("mem_en", bus.mem_en_o, eif || ed);
        check("mem_we", bus.mem_we_o, ed && bus.d_we_i);
        if (eif || ed) check("mem_addr", bus.mem_addr_o, eif ? bus.if_addr_i : bus.d_addr_i);
        check("mem_wdata", bus.mem_wdata_o, ed ? bus.d_wdata_i : '0);
        check("if_rvalid", bus.if_rvalid_o, pend == 1);
        check("if_rdata", bus.if_rdata_o, pend == 1 ? ref_mem[pend_addr] : '0);
        check("d_rvalid", bus.d_rvalid_o, pend == 2);
        check("d_rdata", bus.d_rdata_o, pend == 2 ? ref_mem[pend_addr] : '0);
        streak = (bus.if_req_i && bus.d_req_i && ed) ? streak + 1 : 0;
        pend = eif ? 1 : (ed && !bus.d_we_i) ? 2 : 0;
        pend_addr = eif ? bus.if_addr_i : bus.d_addr_i;
        if (ed && bus.d_we_i) ref_mem[bus.d_addr_i] = bus.d_wdata_i;
      end
    end
  end
  initial begin
    logic [5:0] seq;
    logic gi, gd;
    bus.if_req_i = 1'b1; bus.if_addr_i = '0;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    repeat (2) @(negedge clk);
    check("lit_rst_if_gnt", bus.if_gnt_o, 0);
    check("lit_rst_d_gnt", bus.d_gnt_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; bus.d_req_i = 1'b0; bus.if_addr_i = 8'h05;
    @(negedge clk);
    check("lit_fetch_gnt", bus.if_gnt_o, 1);
    check("lit_fetch_addr", bus.mem_addr_o, 8'h05);
    @(posedge clk); #1;
    bus.if_req_i = 1'b0; bus.d_req_i = 1'b1; bus.d_addr_i = 8'h10;
    @(negedge clk);
    check("lit_fetch_rvalid", bus.if_rvalid_o, 1);
    check("lit_fetch_rdata", bus.if_rdata_o, 32'hC0FFEE05);
    check("lit_load_gnt", bus.d_gnt_o, 1);
    check("lit_no_d_rvalid", bus.d_rvalid_o, 0);
    @(posedge clk); #1;
    bus.d_we_i = 1'b1; bus.d_addr_i = 8'h20; bus.d_wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    check("lit_load_rdata", bus.d_rdata_o, 32'hC0FFEE10);
    check("lit_fetch_rvalid_gone", bus.if_rvalid_o, 0);
    check("lit_store_we", bus.mem_we_o, 1);
    @(posedge clk); #1;
    bus.d_we_i = 1'b0;
    @(negedge clk);
    check("lit_store_no_rvalid", bus.d_rvalid_o, 0);
    check("lit_store_we_one_cycle", bus.mem_we_o, 0);
    @(posedge clk); #1;
    bus.d_req_i = 1'b0;
    @(negedge clk);
    check("lit_reload", bus.d_rdata_o, 32'hDEADBEEF);
    @(posedge clk); #1;
    bus.if_req_i = 1'b1; bus.d_req_i = 1'b1; bus.if_addr_i = 8'h01; bus.d_addr_i = 8'h02;
    seq = '0;
    repeat (6) begin
      @(negedge clk); seq = {seq[4:0], bus.if_gnt_o};
      @(posedge clk); #1;
    end
    check("lit_grant_seq_DDFDDF", seq, 6'b001001);
    seq = '0;
    @(negedge clk); seq = {seq[4:0], bus.if_gnt_o};
    @(posedge clk); #1; bus.if_req_i = 1'b0;
    @(negedge clk); seq = {seq[4:0], bus.if_gnt_o};
    @(posedge clk); #1; bus.if_req_i = 1'b1;
    repeat (3) begin
      @(negedge clk); seq = {seq[4:0], bus.if_gnt_o};
      @(posedge clk); #1;
    end
    check("lit_streak_restart", seq[4:0], 5'b00001);
    bus.if_req_i = 1'b0; bus.d_addr_i = 8'h10;
    @(negedge clk);
    check("lit_load_before_rst", bus.d_gnt_o, 1);
    @(posedge clk); #1;
    rst = 1'b1; bus.if_req_i = 1'b1;
    @(negedge clk);
    check("lit_rst_drops_rvalid", bus.d_rvalid_o, 0);
    check("lit_rst_gnts", {bus.if_gnt_o, bus.d_gnt_o}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
    @(negedge clk);
    check("lit_post_rst_rvalid", {bus.if_rvalid_o, bus.d_rvalid_o}, 2'b00);
    repeat (3000) begin
      gi = bus.if_gnt_o;
      gd = bus.d_gnt_o;
      @(posedge clk); #1;
      rst = ($urandom_range(99) == 0);
      if (gi || !bus.if_req_i) begin
        bus.if_req_i = ($urandom_range(3) != 0);
        bus.if_addr_i = 8'($urandom_range(15));
      end
      if (gd || !bus.d_req_i) begin
        bus.d_req_i = ($urandom_range(3) != 0);
        bus.d_we_i = 1'($urandom_range(1));
        bus.d_addr_i = 8'($urandom_range(15));
        bus.d_wdata_i = $urandom;
      end
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
